// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants and sequencer state encoding
//   CALC_WIDTH : operand width of the calculator registers
//   CALC_CNT_W : iteration counter width able to hold CALC_WIDTH
//   state_e    : multiply/divide sequencer states
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_CNT_W = $clog2(CALC_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/iter_cnt.sv
// rtl/iter_cnt.sv - loadable iteration down-counter with zero flag
//   clk_i      : system clock, rising edge
//   rst_ni     : asynchronous active-low reset, clears the count
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, saturating at zero
//   cnt_o      : current count
//   zero_o     : count is zero
module iter_cnt #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - radix-2 shift-add multiply sequencer (Booth recoding with MUL_SEQ_BOOTH_EN)
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : request a multiply, honoured only in IDLE
//   abort    : synchronous cancel of a running operation
//   q0       : LSB of the Q register
//   q_m1     : Booth history bit (used only with MUL_SEQ_BOOTH_EN)
//   ld_m     : load M from operand bus
//   ld_q     : load Q from operand bus
//   clr_a    : clear A
//   add_en   : A <= A + M this cycle
//   sub_en   : A <= A - M this cycle (Booth build only, else 0)
//   shift_en : shift {A,Q} right one bit
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//   cnt      : remaining iterations
module mul_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             q0,
  input  logic             q_m1,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  state_e state_q;
  logic   load_str_q;
  logic   shift_str_q;
  logic   busy_q;
  logic   done_q;

  logic             active;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             in_test;

  assign active = (state_q != IDLE);

  // An abort reloads the counter with zero so the block returns to IDLE
  // with the same cnt value it has after reset.
  assign cnt_load     = (active && abort) || (state_q == LOAD);
  assign cnt_load_val = abort ? '0 : CNT_W'(WIDTH);
  assign cnt_dec      = (state_q == SHIFT) && !abort;

  iter_cnt #(
    .W(CNT_W)
  ) u_iter_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .cnt_o     (cnt),
    .zero_o    (cnt_zero)
  );

  // Moore strobes are registered from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      load_str_q  <= 1'b0;
      shift_str_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      load_str_q  <= 1'b0;
      shift_str_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      if (active && abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= LOAD;
              load_str_q <= 1'b1;
            end else begin
              busy_q <= 1'b0;
            end
          end
          LOAD: state_q <= TEST;
          TEST: begin
            state_q     <= SHIFT;
            shift_str_q <= 1'b1;
          end
          SHIFT: begin
            // cnt_zero guards against ever wrapping below the last iteration.
            if ((cnt == CNT_W'(1)) || cnt_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= TEST;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Datapath strobes are masked while abort is high; done and busy are not.
  assign ld_m     = load_str_q & ~abort;
  assign ld_q     = load_str_q & ~abort;
  assign clr_a    = load_str_q & ~abort;
  assign shift_en = shift_str_q & ~abort;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_test  = (state_q == TEST) & ~abort;

`ifdef MUL_SEQ_BOOTH_EN
  assign add_en = in_test & ~q0 & q_m1;
  assign sub_en = in_test & q0 & ~q_m1;
`else
  logic q_m1_unused;
  assign q_m1_unused = q_m1;
  assign add_en      = in_test & q0;
  assign sub_en      = 1'b0;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl
module tb_mul_seq_ctrl;

  localparam int W  = 16;
  localparam int CW = 5;
`ifdef MUL_SEQ_BOOTH_EN
  localparam bit BOOTH = 1'b1;
`else
  localparam bit BOOTH = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          chk_prod;
    logic [31:0] prod;
    logic [15:0] amask;
    logic [15:0] smask;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort, q0, q_m1;
  logic ld_m, ld_q, clr_a, add_en, sub_en, shift_en, busy, done;
  logic [CW-1:0] cnt;

  mul_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0), .q_m1(q_m1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .add_en(add_en), .sub_en(sub_en),
    .shift_en(shift_en), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int exp_load_q[$];
  exp_t exp_done_q[$];

  int          mode = 3;
  logic        q0_rand = 1'b0;
  logic [15:0] q_op = '0;
  logic [15:0] m_op = '0;

  logic [16:0] ma = '0;
  logic [15:0] mq = '0;
  logic [15:0] mm = '0;
  logic        mqm1 = 1'b0;
  int          nshift = 0;
  logic [15:0] amask = '0;
  logic [15:0] smask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always_comb begin
    q0   = mq[0];
    q_m1 = mqm1;
    case (mode)
      1: begin q0 = 1'b1; q_m1 = 1'b0; end
      2: begin
        q0   = (nshift == 0) || (nshift == 2);
        q_m1 = (nshift == 1) || (nshift == 2);
      end
      3: begin q0 = q0_rand; q_m1 = q0_rand; end
      default: ;
    endcase
  end

  // Monitor and datapath model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (add_en | sub_en | shift_en | ld_m)
        chk("strobe_excl", 32'((add_en | sub_en) & (shift_en | ld_m | ld_q)), 32'd0);
      if (ld_m) begin
        if (exp_load_q.size() == 0) begin
          chk("unexpected_load", 32'd1, 32'd0);
        end else begin
          chk("load_cycle", 32'(cyc), 32'(exp_load_q.pop_front()));
        end
        chk("load_strobes", {29'd0, ld_q, clr_a, busy}, 32'd7);
        nshift = 0;
        amask  = '0;
        smask  = '0;
      end
      if (add_en && nshift < W) amask[nshift] = 1'b1;
      if (sub_en && nshift < W) smask[nshift] = 1'b1;
      if (shift_en) begin
        chk("shift_cnt", 32'(cnt), 32'(W - nshift));
        nshift++;
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_cnt", 32'(cnt), 32'd0);
          chk("done_shifts", 32'(nshift), 32'(W));
          chk("add_mask", 32'(amask), 32'(e.amask));
          chk("sub_mask", 32'(smask), 32'(e.smask));
          if (e.chk_prod) chk("product", {ma[15:0], mq}, e.prod);
        end
      end
      if (ld_m) mm = m_op;
      if (ld_q) begin mq = q_op; mqm1 = 1'b0; end
      if (clr_a) ma = '0;
      if (BOOTH) begin
        if (add_en) ma[15:0] = ma[15:0] + mm;
        if (sub_en) ma[15:0] = ma[15:0] - mm;
        if (shift_en) begin
          mqm1 = mq[0];
          mq   = {ma[0], mq[15:1]};
          ma   = {1'b0, ma[15], ma[15:1]};
        end
      end else begin
        if (add_en) ma = ma + {1'b0, mm};
        if (shift_en) begin
          mqm1 = mq[0];
          mq   = {ma[0], mq[15:1]};
          ma   = ma >> 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int md, input logic [15:0] qv, input logic [15:0] mv,
                       input bit cp, input logic [31:0] pr,
                       input logic [15:0] am, input logic [15:0] sm, input bit push_done);
    exp_t e;
    mode = md;
    q_op = qv;
    m_op = mv;
    start = 1'b1;
    exp_load_q.push_back(cyc + 1);
    if (push_done) begin
      e.cyc = cyc + 34; e.chk_prod = cp; e.prod = pr; e.amask = am; e.smask = sm;
      exp_done_q.push_back(e);
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // Reset holds everything at zero regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      start   = 1'($urandom_range(0, 1));
      abort   = 1'($urandom_range(0, 1));
      q0_rand = 1'($urandom_range(0, 1));
      tick();
      chk("reset_outputs", 32'({busy, done, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, cnt}), 32'd0);
    end
    start = 1'b0; abort = 1'b0;
    tick();
    rst = 1'b1;
    idle_wait(3);
    chk("idle_after_reset", 32'({busy, ld_m, cnt}), 32'd0);

    // q0 tied high: every iteration adds (subtracts in Booth build).
    issue(1, 16'h0, 16'h0, 1'b0, 32'd0, BOOTH ? 16'h0000 : 16'hFFFF,
          BOOTH ? 16'hFFFF : 16'h0000, 1'b1);
    chk("busy_in_load", 32'(busy), 32'd1);
    idle_wait(40);

    // 5 * 7 through the datapath model.
    issue(0, 16'h0005, 16'h0007, 1'b1, 32'h0000_0023, BOOTH ? 16'h000A : 16'h0005,
          BOOTH ? 16'h0005 : 16'h0000, 1'b1);
    idle_wait(40);

    // Largest operands.
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, BOOTH ? 32'h0000_0001 : 32'hFFFE_0001,
          BOOTH ? 16'h0000 : 16'hFFFF, BOOTH ? 16'h0001 : 16'h0000, 1'b1);
    idle_wait(40);

    // (q0,q_m1) = (1,0), (0,1), (1,1) in the first three TEST cycles.
    issue(2, 16'h0, 16'h0, 1'b0, 32'd0, BOOTH ? 16'h0002 : 16'h0005,
          BOOTH ? 16'h0001 : 16'h0000, 1'b1);
    idle_wait(40);

    // start held high for 100 cycles: three back-to-back operations.
    mode = 0; q_op = 16'h0005; m_op = 16'h0007;
    n = cyc;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_load_q.push_back(n + 1 + 35 * k);
      e.cyc = n + 34 + 35 * k; e.chk_prod = 1'b1; e.prod = 32'h0000_0023;
      e.amask = BOOTH ? 16'h000A : 16'h0005; e.smask = BOOTH ? 16'h0005 : 16'h0000;
      exp_done_q.push_back(e);
    end
    idle_wait(100);
    start = 1'b0;
    idle_wait(15);

    // abort in TEST of iteration 3: strobes suppressed, back to IDLE, no done.
    n = cyc;
    issue(1, 16'h0, 16'h0, 1'b0, 32'd0, 16'h0, 16'h0, 1'b0);
    while (cyc < n + 8) tick();
    abort = 1'b1;
    #1;
    chk("abort_strobes", 32'({add_en, sub_en, shift_en}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'({busy, done, cnt}), 32'd0);
    idle_wait(40);

    // abort together with start in IDLE has no effect.
    abort = 1'b1;
    issue(0, 16'h0005, 16'h0007, 1'b1, 32'h0000_0023, BOOTH ? 16'h000A : 16'h0005,
          BOOTH ? 16'h0005 : 16'h0000, 1'b1);
    idle_wait(40);

    // Asynchronous reset during iteration 7, then a full operation.
    n = cyc;
    issue(1, 16'h0, 16'h0, 1'b0, 32'd0, 16'h0, 16'h0, 1'b0);
    while (cyc < n + 16) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 32'({busy, done, ld_m, ld_q, clr_a, add_en, sub_en, shift_en, cnt}), 32'd0);
    idle_wait(2);
    rst = 1'b1;
    tick();
    issue(0, 16'h0005, 16'h0007, 1'b1, 32'h0000_0023, BOOTH ? 16'h000A : 16'h0005,
          BOOTH ? 16'h0005 : 16'h0000, 1'b1);
    idle_wait(40);

    chk("pending_loads", 32'(exp_load_q.size()), 32'd0);
    chk("pending_dones", 32'(exp_done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
